// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto a single-port RAM using the MOV/R_W/MOC handshake.
// Defining MEM_TIMEOUT_EN adds a MOC watchdog that aborts a stalled access with an err pulse.
module mem_access_arbiter #(
  parameter int AW             = 32,
  parameter int STARVE_LIMIT   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          mem_mov,
  output logic          mem_rw,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_moc,
  output logic          busy,
  output logic          err
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   starve_r, starve_s;
  logic            sel_data_r, sel_data_s;
  logic            grant_data_s, grant_fetch_s, done_s, timeout_s;
  logic            mem_mov_s, mem_rw_s, if_ack_s, d_ack_s, busy_s, err_s;
  logic [1:0]      mem_size_s;
  logic [AW-1:0]   mem_addr_s;
  logic [31:0]     mem_wdata_s, if_rdata_s, d_rdata_s, cap_rdata_s;

  // Data normally wins; a fetch passed over STARVE_LIMIT times in a row is forced through.
  assign grant_data_s  = (state_r == ST_IDLE) && d_req && (!if_req || (starve_r != STARVE_MAX));
  assign grant_fetch_s = (state_r == ST_IDLE) && if_req && !grant_data_s;
  assign done_s        = (state_r == ST_WAIT) && mem_moc;
  assign cap_rdata_s   = done_s ? mem_rdata : 32'h0000_0000;

`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wait_cnt_r;

  assign timeout_s = (state_r == ST_WAIT) && !mem_moc && (wait_cnt_r == WAIT_LAST);

  // Watchdog counts WAIT cycles; held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt_r <= {WW{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= {WW{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (if_req || d_req) state_s = ST_WAIT;
        else                 state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (done_s || timeout_s) state_s = ST_ACK;
        else                     state_s = ST_WAIT;
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of every registered output plus grant bookkeeping.
  always_comb begin
    mem_mov_s   = mem_mov;
    mem_rw_s    = mem_rw;
    mem_size_s  = mem_size;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    if_rdata_s  = if_rdata;
    d_rdata_s   = d_rdata;
    if_ack_s    = 1'b0;
    d_ack_s     = 1'b0;
    err_s       = 1'b0;
    starve_s    = starve_r;
    sel_data_s  = sel_data_r;
    busy_s      = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (grant_data_s) begin
          sel_data_s  = 1'b1;
          mem_mov_s   = 1'b1;
          mem_rw_s    = ~d_we;
          mem_size_s  = d_size;
          mem_addr_s  = d_addr;
          mem_wdata_s = d_wdata;
          if (!if_req)                   starve_s = {SW{1'b0}};
          else if (starve_r != STARVE_MAX) starve_s = starve_r + 1'b1;
          else                           starve_s = starve_r;
        end else if (grant_fetch_s) begin
          sel_data_s  = 1'b0;
          mem_mov_s   = 1'b1;
          mem_rw_s    = 1'b1;
          mem_size_s  = 2'b10;
          mem_addr_s  = if_addr;
          starve_s    = {SW{1'b0}};
        end else begin
          starve_s    = {SW{1'b0}};
        end
      end
      ST_WAIT: begin
        // A MOC coinciding with the timeout wins: timeout_s already excludes mem_moc.
        if (done_s || timeout_s) begin
          mem_mov_s = 1'b0;
          err_s     = timeout_s;
          if (sel_data_r) begin
            d_ack_s = 1'b1;
            if (mem_rw) d_rdata_s = cap_rdata_s;
            else        d_rdata_s = d_rdata;
          end else begin
            if_ack_s   = 1'b1;
            if_rdata_s = cap_rdata_s;
          end
        end else begin
          mem_mov_s = 1'b1;
        end
      end
      ST_ACK:  mem_mov_s = 1'b0;
      default: mem_mov_s = 1'b0;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem_mov    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_size   <= 2'b00;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= 32'h0000_0000;
      if_ack     <= 1'b0;
      if_rdata   <= 32'h0000_0000;
      d_ack      <= 1'b0;
      d_rdata    <= 32'h0000_0000;
      busy       <= 1'b0;
      err        <= 1'b0;
      starve_r   <= {SW{1'b0}};
      sel_data_r <= 1'b0;
    end else begin
      mem_mov    <= mem_mov_s;
      mem_rw     <= mem_rw_s;
      mem_size   <= mem_size_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
      if_ack     <= if_ack_s;
      if_rdata   <= if_rdata_s;
      d_ack      <= d_ack_s;
      d_rdata    <= d_rdata_s;
      busy       <= busy_s;
      err        <= err_s;
      starve_r   <= starve_s;
      sel_data_r <= sel_data_s;
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: randomized accesses against a transaction-level model
// of arbitration, latency and read-data bookkeeping.
module tb_mem_access_arbiter;
  localparam int AW    = 32;
  localparam int LIMIT = 2;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic          Clk, Reset;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [31:0]   if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [1:0]    d_size, mem_size;
  logic          mem_mov, mem_rw, mem_moc, busy, err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  int passes;

  mem_access_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc),
    .busy(busy), .err(err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One access from an IDLE cycle with requests already presented; returns in the ack cycle.
  task automatic drive_txn(input bit scramble, input int w, input bit force_rd,
                           input logic [31:0] rd_val, output bit was_data);
    bit exp_d, store;
    logic [AW-1:0] ea;
    logic ew;
    logic [1:0] es;
    logic [31:0] ewd, rd;
    mem_moc = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_mov !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL idle_gap busy=%b mov=%b if_ack=%b d_ack=%b, required all 0", busy, mem_mov, if_ack, d_ack);
    end
    exp_d = d_req && (!if_req || passes < LIMIT);
    if (exp_d) begin
      ea = d_addr; ew = ~d_we; es = d_size; ewd = d_wdata;
      passes = if_req ? ((passes < LIMIT) ? passes + 1 : LIMIT) : 0;
    end else begin
      ea = if_addr; ew = 1'b1; es = 2'b10; ewd = 32'h0;
      passes = 0;
    end
    store = exp_d && d_we;
    rd = 32'h0;
    tick();
    for (int c = 1; c <= w; c++) begin
      checks++;
      if (mem_mov !== 1'b1 || mem_addr !== ea || mem_rw !== ew || mem_size !== es ||
          (exp_d && mem_wdata !== ewd) || if_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_cycle%0d mov=%b addr=%h rw=%b size=%b wdata=%h acks=%b%b busy=%b, required mov=1 addr=%h rw=%b size=%b wdata=%h acks=00 busy=1",
                 c, mem_mov, mem_addr, mem_rw, mem_size, mem_wdata, if_ack, d_ack, busy, ea, ew, es, ewd);
      end
      if (scramble) begin
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
      end
      rd = (force_rd && c == w) ? rd_val : $urandom;
      mem_rdata = rd;
      mem_moc = (c == w);
      tick();
    end
    mem_moc = 1'($urandom_range(0, 1));
    if (!store) begin
      if (exp_d) exp_d_rdata = rd;
      else       exp_if_rdata = rd;
    end
    checks++;
    if (if_ack !== !exp_d || d_ack !== exp_d || mem_mov !== 1'b0 || busy !== 1'b1 || err !== 1'b0 ||
        if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
      failures++;
      $display("FAIL ack_cycle if_ack=%b d_ack=%b mov=%b busy=%b err=%b if_rdata=%h d_rdata=%h, required if_ack=%b d_ack=%b mov=0 busy=1 err=0 if_rdata=%h d_rdata=%h",
               if_ack, d_ack, mem_mov, busy, err, if_rdata, d_rdata, !exp_d, exp_d, exp_if_rdata, exp_d_rdata);
    end
    was_data = exp_d;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_moc = 1'b0;
    #3;
    checks++;
    if (mem_mov !== 1'b0 || mem_rw !== 1'b0 || mem_size !== 2'b00 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || if_ack !== 1'b0 || d_ack !== 1'b0 || if_rdata !== 32'h0 ||
        d_rdata !== 32'h0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values mov=%b rw=%b size=%b addr=%h wdata=%h acks=%b%b rdata=%h/%h busy=%b err=%b, required all 0",
               mem_mov, mem_rw, mem_size, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, busy, err);
    end
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; passes = 0;
    tick(); tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic post_idle(input string name);
    tick();
    mem_moc = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_mov !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s busy=%b mov=%b if_ack=%b d_ack=%b, required all 0", name, busy, mem_mov, if_ack, d_ack);
    end
  endtask

  task automatic test_fetch();
    bit g;
    if_req = 1'b1; if_addr = 32'h0000_0100; d_req = 1'b0;
    drive_txn(1'b1, 2, 1'b1, 32'hE3A0_1005, g);
    if_req = 1'b0;
    post_idle("fetch_busy_low");
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = $urandom;
      drive_txn(1'b1, $urandom_range(1, 5), 1'b0, 32'h0, g);
      if_req = 1'b0;
      post_idle("fetch_rand_idle");
    end
  endtask

  task automatic test_store();
    bit g;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h0000_0204; d_wdata = 32'h0000_00AB;
    drive_txn(1'b1, 4, 1'b0, 32'h0, g);
    d_req = 1'b0;
    post_idle("store_idle");
    for (int i = 0; i < 6; i++) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
      d_addr = $urandom; d_wdata = $urandom;
      drive_txn(1'b1, $urandom_range(1, 5), 1'b0, 32'h0, g);
      d_req = 1'b0;
      post_idle("data_rand_idle");
    end
  endtask

  task automatic test_contention();
    bit g;
    if_req = 1'b1; if_addr = $urandom;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = $urandom; d_wdata = $urandom;
    for (int i = 0; i < 9; i++) begin
      drive_txn(1'b0, $urandom_range(1, 5), 1'b0, 32'h0, g);
      checks++;
      if (g !== (i % 3 != 2)) begin
        failures++;
        $display("FAIL grant_order%0d data_granted=%b, required %b", i, g, (i % 3 != 2));
      end
      if (g) begin
        d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end else begin
        if_addr = $urandom;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    mem_moc = 1'b0;
    tick();
  endtask

  task automatic test_moc_glitch();
    tick();
    mem_moc = 1'b1;
    tick();
    mem_moc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || mem_mov !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0 ||
          if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
        failures++;
        $display("FAIL moc_glitch busy=%b mov=%b acks=%b%b rdata=%h/%h, required busy=0 mov=0 acks=00 rdata=%h/%h",
                 busy, mem_mov, if_ack, d_ack, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit g;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = $urandom; d_wdata = $urandom;
    tick();
    tick();
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (mem_mov !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid mov=%b busy=%b d_ack=%b rdata=%h/%h, required all 0", mem_mov, busy, d_ack, if_rdata, d_rdata);
    end
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; passes = 0;
    d_req = 1'b0;
    tick();
    Reset = 1'b1;
    post_idle("reset_mid_no_ack");
    if_req = 1'b1; if_addr = $urandom;
    drive_txn(1'b1, $urandom_range(1, 4), 1'b0, 32'h0, g);
    if_req = 1'b0;
    post_idle("reset_mid_recover");
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = $urandom; d_wdata = $urandom;
    mem_moc = 1'b0;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      checks++;
      if (mem_mov !== 1'b1 || d_ack !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d mov=%b d_ack=%b err=%b, required 1 0 0", c, mem_mov, d_ack, err);
      end
      tick();
    end
    exp_d_rdata = 32'h0;
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b1 || mem_mov !== 1'b0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_abort d_ack=%b err=%b mov=%b d_rdata=%h, required 1 1 0 00000000", d_ack, err, mem_mov, d_rdata);
    end
    d_req = 1'b0;
    post_idle("timeout_idle");
`else
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (mem_mov !== 1'b1 || d_ack !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL no_timeout%0d mov=%b d_ack=%b busy=%b err=%b, required 1 0 1 0", c, mem_mov, d_ack, busy, err);
      end
      tick();
    end
    #2;
    Reset = 1'b0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; passes = 0;
    d_req = 1'b0;
    tick();
    Reset = 1'b1;
    post_idle("no_timeout_recover");
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_moc_glitch();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
